// File: rtl/matmul_op_sequencer.sv
// Purpose: sequences one matrix multiply: clear array, stream masked A/B rows, drain, pulse done.
// Latency: start_bit sampled in IDLE -> done 16 cycles later at default parameters, independent of dims.
// Backpressure: none; rows stream one per cycle and start_bit is ignored while busy.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   start_bit, dim_n/k/m     operation request and matrix dimensions (minus 1), latched in IDLE
//   rd_addr_a/b, rd_data_a/b register-file read ports for operands A and B
//   row_a, row_b, row_valid,
//   row_idx                  masked operand rows to the padding/skew stage (registered)
//   array_clear, busy, done,
//   op_lock                  array control and status
module matmul_op_sequencer #(
    parameter int data_width   = 16,
    parameter int bus_width    = 64,
    parameter int a_base       = 4,
    parameter int b_base       = 8,
    parameter int drain_cycles = 10
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start_bit,
    input  logic [1:0]                                  dim_n,
    input  logic [1:0]                                  dim_k,
    input  logic [1:0]                                  dim_m,
    output logic [4:0]                                  rd_addr_a,
    input  logic [bus_width-1:0]                        rd_data_a,
    output logic [4:0]                                  rd_addr_b,
    input  logic [bus_width-1:0]                        rd_data_b,
    output logic [bus_width-1:0]                        row_a,
    output logic [bus_width-1:0]                        row_b,
    output logic                                        row_valid,
    output logic [$clog2(bus_width/data_width)-1:0]     row_idx,
    output logic                                        array_clear,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        op_lock
);

    localparam int max_dim = bus_width / data_width;
    localparam int idx_w   = $clog2(max_dim);
    localparam int drain_w = $clog2(drain_cycles + 1);

    localparam logic [idx_w-1:0]   last_idx   = idx_w'(max_dim - 1);
    localparam logic [drain_w-1:0] last_drain = drain_w'(drain_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [idx_w-1:0]     idx_q;
    logic [drain_w-1:0]   drain_cnt_q;
    logic [1:0]           n_q;
    logic [1:0]           k_q;
    logic [1:0]           m_q;
    logic [bus_width-1:0] mask_a;
    logic [bus_width-1:0] mask_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_bit) state_d = CLEAR;
            CLEAR:   state_d = STREAM;
            STREAM:  if (idx_q == last_idx) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == last_drain) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign op_lock     = busy;
    assign array_clear = (state_q == CLEAR);
    assign done        = (state_q == DONE);

    // Read addresses follow the row index only while streaming; they read
    // as zero while reset is held so the whole port is quiet during reset.
    always_comb begin
        rd_addr_a = 5'(a_base);
        rd_addr_b = 5'(b_base);
        if (reset) begin
            rd_addr_a = '0;
            rd_addr_b = '0;
        end else if (state_q == STREAM) begin
            rd_addr_a = 5'(a_base) + 5'(idx_q);
            rd_addr_b = 5'(b_base) + 5'(idx_q);
        end
    end

    // A is n x k: row idx beyond n or lane beyond k is outside the matrix.
    // B is k x m: row idx beyond k or lane beyond m is outside the matrix.
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int l = 0; l < max_dim; l++) begin
            if ((int'(idx_q) <= int'(n_q)) && (l <= int'(k_q))) begin
                mask_a[l*data_width +: data_width] = rd_data_a[l*data_width +: data_width];
            end
            if ((int'(idx_q) <= int'(k_q)) && (l <= int'(m_q))) begin
                mask_b[l*data_width +: data_width] = rd_data_b[l*data_width +: data_width];
            end
        end
    end

    // Datapath: latched dims, counters and registered row outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            row_a       <= '0;
            row_b       <= '0;
            row_valid   <= 1'b0;
            row_idx     <= '0;
        end else begin
            // Dims are captured only on the accepted start so the operation
            // is immune to dim_* changes until it finishes.
            if (state_q == IDLE && start_bit) begin
                n_q <= dim_n;
                k_q <= dim_k;
                m_q <= dim_m;
            end

            idx_q       <= (state_q == STREAM) ? idx_q + idx_w'(1) : '0;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + drain_w'(1) : '0;

            row_valid <= (state_q == STREAM);
            row_idx   <= (state_q == STREAM) ? idx_q  : '0;
            row_a     <= (state_q == STREAM) ? mask_a : '0;
            row_b     <= (state_q == STREAM) ? mask_b : '0;
        end
    end

endmodule

// File: tb/tb_matmul_op_sequencer.sv
// Purpose: self-checking bench for matmul_op_sequencer with a row scoreboard.
// Latency: checks start->done timing of 16 cycles and row_valid window T+3..T+6.
// Backpressure: not applicable; the bench drives start_bit and dims only.
module tb_matmul_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_bit;
    logic [1:0]  dim_n, dim_k, dim_m;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic [63:0] row_a, row_b;
    logic        row_valid;
    logic [1:0]  row_idx;
    logic        array_clear, busy, done, op_lock;

    logic [63:0] rf [0:31];

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    always #5 clk = ~clk;

    matmul_op_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start_bit   (start_bit),
        .dim_n       (dim_n),
        .dim_k       (dim_k),
        .dim_m       (dim_m),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .row_a       (row_a),
        .row_b       (row_b),
        .row_valid   (row_valid),
        .row_idx     (row_idx),
        .array_clear (array_clear),
        .busy        (busy),
        .done        (done),
        .op_lock     (op_lock)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  idx;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference masking: keep lane l of row i only if i <= row_lim and l <= lane_lim.
    function automatic logic [63:0] ref_mask(input logic [63:0] d, input int i,
                                             input int row_lim, input int lane_lim);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            if (i <= row_lim && l <= lane_lim) r[l*16 +: 16] = d[l*16 +: 16];
        end
        return r;
    endfunction

    // Scoreboard consumer: every valid row must match the next expected row.
    always @(negedge clk) begin
        if (row_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("row_a", row_a, e.a);
                chk("row_b", row_b, e.b);
                chk("row_idx", 64'(row_idx), 64'(e.idx));
            end
        end
    end

    // Drives start for the current cycle (cycle T) and queues the expected rows.
    task automatic start_op(input int n, input int k, input int m);
        @(posedge clk); #1;
        start_bit = 1'b1;
        dim_n = 2'(n);
        dim_k = 2'(k);
        dim_m = 2'(m);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.a   = ref_mask(rf[4 + i], i, n, k);
            e.b   = ref_mask(rf[8 + i], i, k, m);
            e.idx = 2'(i);
            sb.push_back(e);
        end
    endtask

    // Walks cycles T+1..T+17 checking control timing.
    // kind: 0 plain, 1 start pulse at poke, 2 dims -> 0 at poke,
    //       3 hold start through T+17 (chains), 4 hold start then drop at T+17.
    task automatic run_op(input int kind, input int poke);
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            case (kind)
                1:       start_bit = (c == poke);
                2: begin
                    start_bit = 1'b0;
                    if (c == poke) begin
                        dim_n = 2'd0;
                        dim_k = 2'd0;
                        dim_m = 2'd0;
                    end
                end
                3:       start_bit = 1'b1;
                4:       start_bit = (c < 17);
                default: start_bit = 1'b0;
            endcase
            @(negedge clk);
            chk($sformatf("array_clear@T+%0d", c), 64'(array_clear), 64'(c == 1));
            chk($sformatf("busy@T+%0d", c), 64'(busy), 64'(c <= 16));
            chk($sformatf("op_lock@T+%0d", c), 64'(op_lock), 64'(c <= 16));
            chk($sformatf("done@T+%0d", c), 64'(done), 64'(c == 16));
            chk($sformatf("row_valid@T+%0d", c), 64'(row_valid), 64'(c >= 3 && c <= 6));
            chk($sformatf("rd_addr_a@T+%0d", c), 64'(rd_addr_a),
                (c >= 2 && c <= 5) ? 64'(4 + c - 2) : 64'd4);
            chk($sformatf("rd_addr_b@T+%0d", c), 64'(rd_addr_b),
                (c >= 2 && c <= 5) ? 64'(8 + c - 2) : 64'd8);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row_a"}, row_a, 64'd0);
        chk({tag, "_row_b"}, row_b, 64'd0);
        chk({tag, "_row_valid"}, 64'(row_valid), 64'd0);
        chk({tag, "_row_idx"}, 64'(row_idx), 64'd0);
        chk({tag, "_array_clear"}, 64'(array_clear), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_op_lock"}, 64'(op_lock), 64'd0);
        chk({tag, "_rd_addr_a"}, 64'(rd_addr_a), 64'd0);
        chk({tag, "_rd_addr_b"}, 64'(rd_addr_b), 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++) begin
            rf[4 + i] = {$urandom, $urandom};
            rf[8 + i] = {$urandom, $urandom};
        end
    endtask

    initial begin
        reset     = 1'b1;
        start_bit = 1'b0;
        dim_n     = 2'd0;
        dim_k     = 2'd0;
        dim_m     = 2'd0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rd_addr_a", 64'(rd_addr_a), 64'd4);
        chk("idle_rd_addr_b", 64'(rd_addr_b), 64'd8);
        chk("idle_busy", 64'(busy), 64'd0);

        // Full-size: A rows 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, ...
        for (int i = 0; i < 4; i++) begin
            rf[4 + i] = {16'(4*i + 4), 16'(4*i + 3), 16'(4*i + 2), 16'(4*i + 1)};
            rf[8 + i] = {$urandom, $urandom};
        end
        start_op(3, 3, 3);
        run_op(0, 0);

        // Masking: all-ones operands, n=1 k=2 m=0
        for (int i = 4; i < 12; i++) rf[i] = '1;
        start_op(1, 2, 0);
        run_op(0, 0);

        // Start pulse while busy must be ignored
        fill_random();
        start_op(3, 3, 3);
        run_op(1, 8);
        repeat (3) begin
            @(negedge clk);
            chk("no_restart_busy", 64'(busy), 64'd0);
        end

        // Dim change mid-operation has no effect
        fill_random();
        start_op(3, 3, 3);
        run_op(2, 2);

        // Reset mid-STREAM
        fill_random();
        start_op(3, 3, 3);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start_bit = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done), 64'd0);
            chk("midrst_idle", 64'(busy), 64'd0);
        end
        sb.delete();
        start_op(2, 1, 3);
        run_op(0, 0);

        // Back-to-back with start held high: done at T+16, clear at T+18, done at T+33
        fill_random();
        start_op(3, 3, 3);
        run_op(3, 0);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.a   = rf[4 + i];
            e.b   = rf[8 + i];
            e.idx = 2'(i);
            sb.push_back(e);
        end
        run_op(4, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_op_sequencer.md
Name: matmul_op_sequencer

Overview:
- Controls one matrix-multiply operation, from the start request to the done pulse.
- Clears the systolic array, then reads operand A rows (RF addr 4..7) and operand B rows (RF addr 8..11) through a dedicated read port. Rows are streamed in lockstep to the padding/skew stage, masked to the programmed dimensions.
- Waits for the array to drain, then pulses done.
- Locks operand writes from the APB side while busy, so operands cannot change mid-operation.

Parameters:
- data_width, 16, bits per matrix element.
- bus_width, 64, bits per RF row / APB data.
- a_base, 4, RF address of operand A row 0.
- b_base, 8, RF address of operand B row 0.
- drain_cycles, 10, cycles to wait after the last row for the array to finish (3*max_dim-2).
- localparam max_dim = bus_width/data_width (4).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_bit  in  1  operation request, level sampled in IDLE.
- dim_n  in  2  A rows minus 1.
- dim_k  in  2  A cols / B rows minus 1.
- dim_m  in  2  B cols minus 1.
- rd_addr_a  out  5  RF read address for A.
- rd_data_a  in  bus_width  RF read data for A; combinational from rd_addr_a.
- rd_addr_b  out  5  RF read address for B.
- rd_data_b  in  bus_width  RF read data for B.
- row_a  out  bus_width  masked A row to the padding stage.
- row_b  out  bus_width  masked B row to the padding stage.
- row_valid  out  1  row_a/row_b valid this cycle.
- row_idx  out  $clog2(max_dim)  index of the current row.
- array_clear  out  1  clears array accumulators.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- op_lock  out  1  blocks APB operand writes; equals busy.

Behaviour:
- Reset (synchronous, active-high, highest priority; applies even mid-operation):
  - state goes to IDLE.
  - All outputs are 0, including row_a, row_b, row_idx, rd_addr_a and rd_addr_b.
  - Latched dims and counters are 0.
- IDLE:
  - busy=0.
  - start_bit=1 latches dim_n, dim_k and dim_m into internal registers, then goes to CLEAR.
  - Dims are not re-sampled until the next IDLE, so input changes mid-operation have no effect.
- CLEAR: array_clear=1 for exactly one cycle, then STREAM with idx=0.
- STREAM, for idx 0..max_dim-1, one row per cycle:
  - rd_addr_a = a_base+idx and rd_addr_b = b_base+idx, combinational from state/idx.
  - Registered outputs, valid on the next cycle:
    - row_valid=1, row_idx=idx.
    - row_a = rd_data_a with lane L zeroed if idx>n or L>k.
    - row_b = rd_data_b with lane L zeroed if idx>k or L>m.
  - All max_dim rows are always streamed; out-of-dimension rows are all-zero.
  - After idx=max_dim-1, go to DRAIN.
- DRAIN:
  - Counter counts drain_cycles cycles; row_valid=0 and row_a/row_b are driven to 0.
  - Last count goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 and op_lock=1 in every state except IDLE.
- Outside STREAM, rd_addr_a=a_base and rd_addr_b=b_base.
- start_bit while busy is ignored. No queuing.
- start_bit held high through DONE: IDLE re-samples it and starts a new operation the cycle after DONE.
- Timing for start_bit sampled in IDLE at cycle T:
  - CLEAR at T+1.
  - STREAM at T+2..T+5.
  - row_valid at T+3..T+6.
  - DRAIN at T+6..T+15.
  - done at T+16.
  - IDLE at T+17.
- Latency start→done: 16 cycles at default parameters, independent of dims.

Test Plan:
- Full-size: reset, preload RF[4..7] with A rows 0x0004_0003_0002_0001 etc. and RF[8..11] with B rows; dims n=k=m=3; start 1 cycle → array_clear at T+1; rows 0..3 unchanged at T+3..T+6; done single pulse at T+16.
- Masking: RF all 0xFFFF lanes; n=1, k=2, m=0:
  - row_a = 0x0000_FFFF_FFFF_FFFF for rows 0,1 and 0 for rows 2,3.
  - row_b = 0x0000_0000_0000_FFFF for rows 0..2 and 0 for row 3.
- Start while busy: pulse start_bit at T+8 → no effect, exactly one done at T+16; busy and op_lock high T+1..T+16.
- Dim change mid-op: start with n=k=m=3, then change to 0 at T+2 → rows still fully unmasked.
- Reset mid-STREAM: assert reset at T+4 → next cycle all outputs 0, state IDLE, no done; a new start then completes normally in 16 cycles.
- Back-to-back: hold start_bit high → done at T+16, next array_clear at T+18, next done at T+33.
